pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised, elastic pipeline stage register that replaces the fixed-field inter-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with one reusable block. It carries an arbitrary-width payload with a valid/ready handshake and a two-entry skid buffer, so back-pressure never drops data and ready never depends combinationally on downstream ready. It also supports flush with bubble insertion and keeps a saturating stall-cycle counter for performance debug. One instance sits between each pair of pipeline stages.

## Interface
- DATA_W, 32, payload width in bits (control bundle or instruction word)
- NOP_VALUE, 0, DATA_W-bit value driven on out_data whenever the stage is empty (bubble encoding)
- CNT_W, 16, stall counter width
- clk  in  1  rising-edge clock; the block uses this single clock only
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- in_valid  in  1  upstream presents in_data
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  payload from upstream
- out_valid  out  1  out_data holds a live entry; registered
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head entry, or NOP_VALUE when empty
- flush  in  1  discard all held entries
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Fire rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register (head), skid register, and a state in {EMPTY, ONE, FULL}.
- EMPTY:
  - in_fire -> ONE, main = in_data.
- ONE:
  - in_fire & out_fire -> ONE, main = in_data.
  - in_fire & !out_fire -> FULL, skid = in_data.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL:
  - in_ready = 0, so in_fire cannot occur.
  - out_fire -> ONE, main = skid.
  - Otherwise hold.
- Output and ready mapping:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - Both come straight from the state flops.
- Data ordering: strict FIFO order. No entry is duplicated or lost except by flush.
- Empty registers are loaded with NOP_VALUE, so out_data = NOP_VALUE whenever out_valid = 0.
- Flush (flush = 1 at a clock edge):
  - Next state is EMPTY; main and skid are loaded with NOP_VALUE.
  - Flush takes priority over in_fire; data accepted in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as a completed transfer. Downstream owns that entry.
  - Next cycle: in_ready = 1.
- stall_cnt:
  - Increments by 1 on each edge where out_valid & !out_ready holds in the preceding cycle.
  - Holds at 2^CNT_W-1 once reached.
  - Unaffected by flush; cleared only by reset.
- Reset (reset = 0 at an edge), including mid-transfer or while FULL:
  - state = EMPTY, main = skid = NOP_VALUE, stall_cnt = 0.
  - Outputs after that edge: out_valid = 0, in_ready = 1, out_data = NOP_VALUE.
  - Reset has priority over flush and all handshakes.

## Timing
- Latency: an entry accepted at edge N is visible on out_data with out_valid = 1 after edge N (one cycle) when the stage was EMPTY or ONE-and-draining.
- Throughput: one entry per cycle sustained while out_ready = 1.
- Back-pressure: when out_ready drops, one further upstream entry is absorbed into skid. in_ready falls one cycle later and upstream sees no loss.
- Ready recovery: in_ready returns to 1 one cycle after the first out_fire in FULL.
- No combinational path from out_ready to in_ready, or from in_* to out_*.

## Structure
- Shared package pipe_pkg holds:
  - stage_state_t enum {EMPTY, ONE, FULL}, 2 bits.
  - Default NOP_VALUE constants for instruction and control bundles.
  - The CNT_W default.
- Sub-module sat_counter (parameter W, ports clk, reset, inc, count) implements stall_cnt. It is reusable by other performance counters.
- Everything else is flat in pipe_stage_reg.

## Test plan
- Streaming, DATA_W=32, out_ready=1: drive 0x11, 0x22, 0x33 on consecutive cycles. out_data shows 0x11, 0x22, 0x33 one cycle later with out_valid = 1 and in_ready = 1 throughout.
- Back-pressure: hold out_ready=0 while driving 0xA1, 0xA2, 0xA3.
  - State goes ONE then FULL; in_ready drops after 0xA2, and 0xA3 is held off.
  - Raising out_ready yields 0xA1, 0xA2, then 0xA3 in order.
  - stall_cnt equals the number of stalled cycles.
- Flush while FULL with in_valid=1 carrying 0xFF: the next cycle has out_valid = 0, out_data = NOP_VALUE, in_ready = 1, and 0xFF never appears.
- Saturation, CNT_W=4: stall for 20 cycles. stall_cnt stops at 15 and survives a flush.
- Reset mid-operation: assert reset=0 for one edge while FULL and stalled. After that edge, out_valid = 0, in_ready = 1, stall_cnt = 0, out_data = NOP_VALUE, and a subsequent 0x55 passes with one-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers.
// This file holds the occupancy encoding, the default bubble encodings, and the counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam int DEFAULT_CNT_W = 16;

  // RISC-V canonical NOP (addi x0, x0, 0) for instruction-carrying stages.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  // The all-zero control bundle de-asserts every write enable, so it is harmless.
  localparam logic [31:0] NOP_CTRL  = 32'h0000_0000;

  // Occupancy transition, ignoring flush. The caller applies flush on top of this.
  function automatic stage_state_t stage_next(input stage_state_t state,
                                              input logic         in_fire,
                                              input logic         out_fire);
    stage_state_t next;
    next = state;
    case (state)
      EMPTY: if (in_fire) next = ONE;
      ONE: begin
        if (in_fire && !out_fire)      next = FULL;
        else if (!in_fire && out_fire) next = EMPTY;
      end
      FULL:    if (out_fire) next = ONE;
      default: next = EMPTY;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// It is used for stall_cnt and can be reused by other performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake with a two-entry skid buffer,
// flush with bubble insertion, and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] main_q,  main_d;
  logic [DATA_W-1:0] skid_q,  skid_d;
  logic              in_fire, out_fire;
  logic              stalled;

  // Handshake outputs decode the state flops only, so no input reaches them combinationally.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;

  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;
  assign stalled  = out_valid & ~out_ready;

  // NOTE: the payload registers are reset too. This makes out_data a defined bubble right after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = stage_next(state_q, in_fire, out_fire);
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) main_d = in_data;
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          skid_d = in_data;
        end else if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (out_fire) begin
          main_d = NOP_VALUE;
        end
      end
      FULL: begin
        // The head drains and the skid entry moves up.
        // The vacated skid slot goes back to the bubble value.
        if (out_fire) begin
          main_d = skid_q;
          skid_d = NOP_VALUE;
        end
      end
      default: begin
        main_d = NOP_VALUE;
        skid_d = NOP_VALUE;
      end
    endcase

    // Flush overrides any accept in the same cycle. An out_fire in that cycle still completes downstream.
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stalled),
    .count(stall_cnt)
  );

endmodule
